// File: rtl/fc_mac_sequencer.sv
// Read-address sequencer and quantizing writeback for the FC layer's 20-lane MAC.
// One start pulse issues OUT_NUM x IN_CHUNKS weight/data reads and writes OUT_NUM bytes.
module fc_mac_sequencer #(
    parameter int IN_CHUNKS = 40,
    parameter int OUT_NUM   = 500,
    parameter int WADDR_W   = 15,
    parameter int DADDR_W   = 6,
    parameter int OADDR_W   = 9,
    parameter int SHIFT     = 0,
    parameter bit RELU      = 1'b1
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [WADDR_W-1:0] sram_raddr_weight,
    output logic [DADDR_W-1:0] sram_raddr_data,
    output logic               accumulate_reset,
    input  logic signed [31:0] data_out,
    output logic               sram_write_en,
    output logic [OADDR_W-1:0] sram_waddr,
    output logic signed [7:0]  sram_wdata
);

    localparam int CW = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
    localparam int OW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(IN_CHUNKS - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          first;
        logic          last;
        logic [OW-1:0] o;
    } tag_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      c_cnt;
    logic [OW-1:0]      o_cnt;
    logic [1:0]         drain_cnt;
    logic               issue_last;
    tag_t               issue_tag;
    tag_t               tag_s1;
    tag_t               tag_s2;
    tag_t               tag_s3;
    logic               capture;
    logic signed [31:0] shifted;
    logic signed [7:0]  quant;

    assign issue_last = (state == S_RUN) && (c_cnt == C_LAST) && (o_cnt == O_LAST);

    // NOTE: every register here clears asynchronously on srst, so an abort mid-layer
    // leaves no stale tags that could produce a late write.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: combinational process assigns every output a default first, so no latch
    // can form on a path that leaves something unassigned.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (issue_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'd3) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Weight address doubles as the flat issue index j; all counters park at 0 between layers.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            sram_raddr_weight <= '0;
            c_cnt             <= '0;
            o_cnt             <= '0;
            drain_cnt         <= '0;
        end else begin
            if (state == S_RUN) begin
                if (issue_last) begin
                    sram_raddr_weight <= '0;
                    c_cnt             <= '0;
                    o_cnt             <= '0;
                end else begin
                    sram_raddr_weight <= sram_raddr_weight + 1'b1;
                    if (c_cnt == C_LAST) begin
                        c_cnt <= '0;
                        o_cnt <= o_cnt + 1'b1;
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                    end
                end
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    always_comb begin
        issue_tag.valid = (state == S_RUN);
        issue_tag.first = (c_cnt == '0);
        issue_tag.last  = (c_cnt == C_LAST);
        issue_tag.o     = o_cnt;
    end

    // Data lags weights by one cycle because the MAC registers weights but not src_window.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            sram_raddr_data <= '0;
            tag_s1          <= '0;
            tag_s2          <= '0;
            tag_s3          <= '0;
        end else begin
            // NOTE: non-blocking assignments let the three tag stages shift in one edge
            // without each stage seeing the value written by the stage before it.
            sram_raddr_data <= DADDR_W'(c_cnt);
            tag_s1          <= issue_tag;
            tag_s2          <= tag_s1;
            tag_s3          <= tag_s2;
        end
    end

    assign accumulate_reset = tag_s2.valid & tag_s2.first;
    assign capture          = tag_s3.valid & tag_s3.last;

    always_comb begin
        shifted = data_out >>> SHIFT;
        quant   = shifted[7:0];
        if (RELU && (shifted < 0)) begin
            quant = '0;
        end else if (shifted > 32'sd127) begin
            quant = 8'sd127;
        end else if (shifted < -32'sd128) begin
            quant = -8'sd128;
        end
    end

    // Capture lands on the same edge the next neuron's reset overwrites the MAC sum.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            sram_write_en <= 1'b0;
            sram_waddr    <= '0;
            sram_wdata    <= '0;
        end else begin
            sram_write_en <= capture;
            if (capture) begin
                sram_waddr <= OADDR_W'(tag_s3.o);
                sram_wdata <= quant;
            end
        end
    end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Bench for fc_mac_sequencer: four instances with different SHIFT/RELU share stimulus,
// each driving its own 1-latency SRAM and MAC model; results checked against a layer model.
module tb_fc_mac_sequencer;

    localparam int IC    = 2;
    localparam int ON    = 3;
    localparam int N     = IC * ON;
    localparam int NINST = 4;
    localparam int NCYC  = N + 7;

    logic clk = 1'b0;
    logic srst;
    logic start;

    logic [NINST-1:0]       busy_v;
    logic [NINST-1:0]       done_v;
    logic [NINST-1:0][14:0] raddr_w_v;
    logic [NINST-1:0][5:0]  raddr_d_v;
    logic [NINST-1:0]       acc_rst_v;
    logic [NINST-1:0]       we_v;
    logic [NINST-1:0][8:0]  waddr_v;
    logic [NINST-1:0][7:0]  wdata_v;

    logic [79:0]  wmem [8];
    logic [159:0] dmem [64];
    int           w_ref [N][20];
    int           d_ref [IC][20];
    int           exp_w [NINST][ON];

    logic [14:0]       tr_wa [NINST][NCYC];
    logic [5:0]        tr_da [NINST][NCYC];
    logic              tr_ar [NINST][NCYC];
    logic              tr_bz [NINST][NCYC];
    logic              tr_dn [NINST][NCYC];
    logic              tr_we [NINST][NCYC];
    logic [8:0]        tr_wo [NINST][NCYC];
    logic signed [7:0] tr_wd [NINST][NCYC];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic signed [31:0] dot(input logic [79:0] w, input logic [159:0] d);
        int s;
        s = 0;
        for (int l = 0; l < 20; l++)
            s += int'($signed(w[4*l +: 4])) * int'($signed(d[8*l +: 8]));
        return s;
    endfunction

    for (genvar k = 0; k < NINST; k++) begin : g_dut
        logic [79:0]        wq;
        logic [79:0]        wr;
        logic [159:0]       dq;
        logic signed [31:0] acc = '0;

        fc_mac_sequencer #(
            .IN_CHUNKS(IC),
            .OUT_NUM  (ON),
            .SHIFT    ((k == 1) ? 4 : (k == 3) ? 12 : 0),
            .RELU     (k < 2)
        ) u_dut (
            .clk              (clk),
            .srst             (srst),
            .start            (start),
            .busy             (busy_v[k]),
            .done             (done_v[k]),
            .sram_raddr_weight(raddr_w_v[k]),
            .sram_raddr_data  (raddr_d_v[k]),
            .accumulate_reset (acc_rst_v[k]),
            .data_out         (acc),
            .sram_write_en    (we_v[k]),
            .sram_waddr       (waddr_v[k]),
            .sram_wdata       (wdata_v[k])
        );

        // SRAMs with one cycle of read latency; MAC registers weights, uses data directly.
        always @(posedge clk) begin
            wq  <= wmem[raddr_w_v[k][2:0]];
            dq  <= dmem[raddr_d_v[k]];
            wr  <= wq;
            acc <= acc_rst_v[k] ? dot(wr, dq) : acc + dot(wr, dq);
        end
    end

    function automatic int sh_of(int k);
        return (k == 1) ? 4 : (k == 3) ? 12 : 0;
    endfunction

    function automatic bit rl_of(int k);
        return k < 2;
    endfunction

    // Floor division by 2^sh, optional ReLU, then clamp to a signed byte.
    function automatic int quant(longint s, int sh, bit relu);
        longint div;
        longint v;
        div = longint'(1) << sh;
        v   = s / div;
        if (s < 0 && (s % div) != 0) v = v - 1;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    function automatic bit exp_acc_rst(int t);
        return (t >= 2) && (t - 2 < N) && ((t - 2) % IC == 0);
    endfunction

    function automatic bit exp_we(int t);
        return (t >= 4) && (t - 4 < N) && ((t - 4) % IC == IC - 1);
    endfunction

    function automatic int exp_o(int t);
        return (t - 4) / IC;
    endfunction

    function automatic bit exp_busy(int t);
        return t <= N + 3;
    endfunction

    function automatic bit exp_done(int t);
        return t == N + 4;
    endfunction

    task automatic load_dataset(input int id);
        for (int r = 0; r < N; r++)
            for (int l = 0; l < 20; l++)
                case (id)
                    0:       w_ref[r][l] = 1;
                    1:       w_ref[r][l] = 7;
                    2:       w_ref[r][l] = -8;
                    default: w_ref[r][l] = int'($urandom_range(15, 0)) - 8;
                endcase
        for (int c = 0; c < IC; c++)
            for (int l = 0; l < 20; l++)
                case (id)
                    0:       d_ref[c][l] = 1;
                    1, 2:    d_ref[c][l] = 127;
                    default: d_ref[c][l] = int'($urandom_range(255, 0)) - 128;
                endcase
        for (int r = 0; r < 8; r++) wmem[r] = '0;
        for (int r = 0; r < 64; r++) dmem[r] = '0;
        for (int r = 0; r < N; r++)
            for (int l = 0; l < 20; l++) wmem[r][4*l +: 4] = 4'(w_ref[r][l]);
        for (int c = 0; c < IC; c++)
            for (int l = 0; l < 20; l++) dmem[c][8*l +: 8] = 8'(d_ref[c][l]);
        for (int k = 0; k < NINST; k++)
            for (int o = 0; o < ON; o++) begin
                longint s;
                s = 0;
                for (int c = 0; c < IC; c++)
                    for (int l = 0; l < 20; l++) s += longint'(w_ref[o*IC + c][l] * d_ref[c][l]);
                exp_w[k][o] = quant(s, sh_of(k), rl_of(k));
            end
    endtask

    // Pulse start, then record outputs mid-cycle for T_0 .. T_{N+6}.
    task automatic record_run(input bit extra_starts);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < NCYC; t++) begin
            for (int k = 0; k < NINST; k++) begin
                tr_wa[k][t] = raddr_w_v[k];
                tr_da[k][t] = raddr_d_v[k];
                tr_ar[k][t] = acc_rst_v[k];
                tr_bz[k][t] = busy_v[k];
                tr_dn[k][t] = done_v[k];
                tr_we[k][t] = we_v[k];
                tr_wo[k][t] = waddr_v[k];
                tr_wd[k][t] = wdata_v[k];
            end
            start = extra_starts && (t == 2 || t == N + 4);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        srst  = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            total++;
            if ({busy_v[k], done_v[k], acc_rst_v[k], we_v[k]} !== 4'b0) begin
                bad++;
                $display("FAIL reset_flags k=%0d got=%b want=0000", k,
                         {busy_v[k], done_v[k], acc_rst_v[k], we_v[k]});
            end
            total++;
            if ({raddr_w_v[k], raddr_d_v[k], waddr_v[k], wdata_v[k]} !== '0) begin
                bad++;
                $display("FAIL reset_addr k=%0d got wa=%0d da=%0d oa=%0d wd=%0d want all 0", k,
                         raddr_w_v[k], raddr_d_v[k], waddr_v[k], wdata_v[k]);
            end
        end
        srst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_address_phase();
        load_dataset(0);
        record_run(1'b0);
        for (int t = 0; t < NCYC; t++)
            for (int k = 0; k < NINST; k++) begin
                if (t < N) begin
                    total++;
                    if (tr_wa[k][t] !== 15'(t)) begin
                        bad++;
                        $display("FAIL waddr_weight k=%0d t=%0d got=%0d want=%0d", k, t, tr_wa[k][t], t);
                    end
                end
                if (t >= 1 && t <= N) begin
                    total++;
                    if (tr_da[k][t] !== 6'((t - 1) % IC)) begin
                        bad++;
                        $display("FAIL raddr_data k=%0d t=%0d got=%0d want=%0d", k, t, tr_da[k][t], (t - 1) % IC);
                    end
                end
                total++;
                if (tr_ar[k][t] !== exp_acc_rst(t)) begin
                    bad++;
                    $display("FAIL acc_reset k=%0d t=%0d got=%b want=%b", k, t, tr_ar[k][t], exp_acc_rst(t));
                end
                total++;
                if (tr_bz[k][t] !== exp_busy(t) || tr_dn[k][t] !== exp_done(t)) begin
                    bad++;
                    $display("FAIL busy_done k=%0d t=%0d got=%b%b want=%b%b", k, t,
                             tr_bz[k][t], tr_dn[k][t], exp_busy(t), exp_done(t));
                end
            end
    endtask

    task automatic test_quantize();
        for (int ds = 0; ds < 7; ds++) begin
            load_dataset(ds);
            record_run(1'b0);
            for (int t = 0; t < NCYC; t++)
                for (int k = 0; k < NINST; k++) begin
                    total++;
                    if (tr_we[k][t] !== exp_we(t)) begin
                        bad++;
                        $display("FAIL write_en ds=%0d k=%0d t=%0d got=%b want=%b", ds, k, t, tr_we[k][t], exp_we(t));
                    end else if (exp_we(t)) begin
                        total++;
                        if (tr_wo[k][t] !== 9'(exp_o(t)) || tr_wd[k][t] !== 8'(exp_w[k][exp_o(t)])) begin
                            bad++;
                            $display("FAIL write ds=%0d k=%0d t=%0d got=(%0d,%0d) want=(%0d,%0d)", ds, k, t,
                                     tr_wo[k][t], tr_wd[k][t], exp_o(t), exp_w[k][exp_o(t)]);
                        end
                    end
                end
        end
    endtask

    task automatic test_reset_mid_run();
        load_dataset(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        srst = 1'b1;
        #1;
        for (int k = 0; k < NINST; k++) begin
            total++;
            if ({busy_v[k], done_v[k], acc_rst_v[k], we_v[k], raddr_w_v[k], raddr_d_v[k],
                 waddr_v[k], wdata_v[k]} !== '0) begin
                bad++;
                $display("FAIL abort_zero k=%0d got bz=%b dn=%b ar=%b we=%b wa=%0d da=%0d oa=%0d wd=%0d want all 0",
                         k, busy_v[k], done_v[k], acc_rst_v[k], we_v[k], raddr_w_v[k], raddr_d_v[k],
                         waddr_v[k], wdata_v[k]);
            end
        end
        @(negedge clk);
        srst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            for (int k = 0; k < NINST; k++) begin
                total++;
                if ({we_v[k], done_v[k], busy_v[k]} !== 3'b0) begin
                    bad++;
                    $display("FAIL abort_quiet k=%0d t=%0d got we/done/busy=%b want=000", k, t,
                             {we_v[k], done_v[k], busy_v[k]});
                end
            end
        end
        record_run(1'b0);
        for (int t = 0; t < NCYC; t++)
            for (int k = 0; k < NINST; k++) begin
                total++;
                if ((t < N && tr_wa[k][t] !== 15'(t)) || tr_ar[k][t] !== exp_acc_rst(t)
                    || tr_we[k][t] !== exp_we(t)
                    || (exp_we(t) && tr_wd[k][t] !== 8'(exp_w[k][exp_o(t)]))) begin
                    bad++;
                    $display("FAIL restart k=%0d t=%0d got wa=%0d ar=%b we=%b wd=%0d", k, t,
                             tr_wa[k][t], tr_ar[k][t], tr_we[k][t], tr_wd[k][t]);
                end
            end
    endtask

    task automatic test_start_ignored();
        load_dataset(2);
        record_run(1'b1);
        for (int t = 0; t < NCYC; t++)
            for (int k = 0; k < NINST; k++) begin
                total++;
                if (tr_bz[k][t] !== exp_busy(t) || tr_dn[k][t] !== exp_done(t)
                    || tr_ar[k][t] !== exp_acc_rst(t) || tr_we[k][t] !== exp_we(t)
                    || (t < N && tr_wa[k][t] !== 15'(t))) begin
                    bad++;
                    $display("FAIL start_ignored k=%0d t=%0d got bz=%b dn=%b ar=%b we=%b wa=%0d", k, t,
                             tr_bz[k][t], tr_dn[k][t], tr_ar[k][t], tr_we[k][t], tr_wa[k][t]);
                end else if (exp_we(t)) begin
                    total++;
                    if (tr_wo[k][t] !== 9'(exp_o(t)) || tr_wd[k][t] !== 8'(exp_w[k][exp_o(t)])) begin
                        bad++;
                        $display("FAIL start_ignored_write k=%0d t=%0d got=(%0d,%0d) want=(%0d,%0d)", k, t,
                                 tr_wo[k][t], tr_wd[k][t], exp_o(t), exp_w[k][exp_o(t)]);
                    end
                end
            end
    endtask

    initial begin
        test_reset();
        test_address_phase();
        test_quantize();
        test_reset_mid_run();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fc_mac_sequencer.md
# fc_mac_sequencer

Control and result-writeback engine for the fully-connected layer's 20-lane multiplier-accumulator.
- Forward side: issues weight and input-data SRAM read addresses in the order and phase the MAC expects, and drives the MAC's `accumulate_reset`.
- Return side: captures each finished 32-bit `data_out` sum, applies optional ReLU, arithmetic shift and 8-bit saturation, and writes the byte to the output SRAM.
- One `start` pulse runs a whole FC layer of `OUT_NUM` neurons × `IN_CHUNKS` 20-wide input chunks.

## Interface
- `IN_CHUNKS`, 40: 20-element chunks per output neuron (800 inputs).
- `OUT_NUM`, 500: output neurons per layer.
- `WADDR_W`, 15: weight SRAM address width; must satisfy 2^WADDR_W ≥ IN_CHUNKS·OUT_NUM.
- `DADDR_W`, 6: input-data SRAM address width.
- `OADDR_W`, 9: output SRAM address width.
- `SHIFT`, 0: arithmetic right shift applied before saturation.
- `RELU`, 1: 1 = clamp negative results to 0.
- `clk`  in  1  sole clock, rising edge.
- `srst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  one-cycle layer start; ignored while `busy`.
- `busy`  out  1  high from the cycle after accepted `start` through the final write cycle.
- `done`  out  1  one-cycle pulse, cycle after the final write.
- `sram_raddr_weight`  out  WADDR_W  weight row address (20×4-bit row per address).
- `sram_raddr_data`  out  DADDR_W  input row address (20×8-bit row per address).
- `accumulate_reset`  out  1  to MAC; high on the MAC cycle of each neuron's chunk 0.
- `data_out`  in  32  signed MAC sum.
- `sram_write_en`  out  1  output SRAM write strobe, active-high.
- `sram_waddr`  out  OADDR_W  output neuron index.
- `sram_wdata`  out  8  signed quantized result.

## Operation
- FSM states:
  - IDLE: on `start` → RUN.
  - RUN: issues one read per cycle, no stalls; after issue index N−1 (N = IN_CHUNKS·OUT_NUM) → DRAIN.
  - DRAIN: waits 4 cycles → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- Issue index j = o·IN_CHUNKS + c.
  - c = chunk counter, 0..IN_CHUNKS−1, wraps to 0 and increments o.
  - o = neuron counter, 0..OUT_NUM−1.
  - Weight address = j (weights stored neuron-major, chunk-minor).
  - Data address = c.
- MAC phase rule: the MAC registers weights internally but uses `src_window` directly. Weights are therefore requested one cycle ahead of data; SRAMs have 1-cycle read latency.
- A 3-stage tag pipeline carries valid/first/last/o alongside each issue:
  - first (c==0) drives `accumulate_reset`.
  - last (c==IN_CHUNKS−1) triggers capture.
- Quantize `data_out`:
  - v = data_out >>> SHIFT (truncating toward −∞).
  - If RELU and v<0, v = 0.
  - Saturate to [−128, 127].
  - Register result to `sram_wdata`, o to `sram_waddr`, and assert `sram_write_en`.
- `accumulate_reset`=0 on non-valid pipeline slots; the MAC's idle accumulation is don't-care.

## Timing
- Issue j occurs in cycle T_j. T_0 is the cycle after the edge that samples `start`=1. T_j = T_0 + j.
- `sram_raddr_weight` = j during T_j.
- `sram_raddr_data` = c during T_j+1.
- `accumulate_reset` = (c==0) during T_j+2.
- For the last chunk of neuron o (index L):
  - `data_out` holds the full sum of neuron o during T_L+3.
  - `sram_write_en`=1, `sram_waddr`=o, and `sram_wdata` are valid during T_L+4 only.
- Back-to-back neurons:
  - Next neuron's `accumulate_reset` lands in T_L+3, the same cycle as capture.
  - Capture samples before the MAC sum is overwritten; no bubble is required.
- `done`=1 during T_{N−1}+5; `busy` drops that same cycle.
- Total: N+5 cycles from the start-sampling edge to `done`.
- Reset values: all addresses 0; `accumulate_reset`, `sram_write_en`, `busy`, `done` = 0; `sram_wdata`=0; FSM = IDLE; counters and tag pipeline cleared.
- `srst` mid-run:
  - Abort immediately; outputs take reset values asynchronously.
  - No further writes; no `done`.
  - A fresh `start` restarts from j=0.
- `start` while `busy`: ignored, no restart, timing unchanged.
- `start` during the DONE cycle: ignored.
- `start` in IDLE: accepted the cycle after DONE.

## Test plan
Test configuration: IN_CHUNKS=2, OUT_NUM=3, behavioral 1-latency SRAMs + MAC model.
- Address/phase check:
  - Stimulus: `start`.
  - Weight addr 0,1,2,3,4,5 in T_0..T_5.
  - Data addr 0,1,0,1,0,1 in T_1..T_6.
  - `accumulate_reset` high exactly in T_2, T_4, T_6.
  - `done` at T_10.
- Basic sum, SHIFT=0: all weights 1, all data 1.
  - Each sum = 40.
  - Writes (addr, data) = (0,40), (1,40), (2,40) in T_5, T_7, T_9.
- Saturation, SHIFT=4: data 127, weights 7.
  - Sum = 2·20·889 = 35560; 35560>>>4 = 2222.
  - `sram_wdata` = 127 for all three writes.
- Negative path: data 127, weights −8.
  - RELU=1 → 0.
  - RELU=0, SHIFT=0 → −128.
  - RELU=0, SHIFT=12, sum −40640 → −10.
- Reset mid-run: assert `srst` in T_3.
  - All outputs 0 within the reset cycle; no write for neuron 1.
  - Re-`start` reproduces the full address sequence from 0.
- `start` pulses at T_2 and at the DONE cycle: ignored, waveform identical to the single-start run.
